// File: rtl/l2_cache_control.sv
// L2 cache controller FSM: hit/miss handling, dirty-victim writeback,
// line allocation from physical memory, saturating miss/writeback counters.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for an upstream read or write request
// CHECK     | tag compare result is valid; complete on hit, pick victim on miss
// WRITEBACK | writing the dirty victim line back to physical memory
// ALLOCATE  | reading the missing line from physical memory into the victim way
module l2_cache_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             hit,
  input  logic [2:0]       hit_way,
  input  logic [2:0]       lru_way,
  input  logic             victim_dirty,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [3:0]       pmem_addr_mux_sel,
  output logic             data_in_mux_sel,
  output logic [1:0]       data_write_en_mux_sel,
  output logic [2:0]       way_sel,
  output logic             load_tag,
  output logic             load_valid,
  output logic             set_dirty,
  output logic             clear_dirty,
  output logic             lru_update,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} state_t;

  localparam logic [3:0] ADDR_CPU      = 4'd0;
  localparam logic       DIN_CACHELINE = 1'b0;
  localparam logic       DIN_BUS       = 1'b1;
  localparam logic [1:0] WEN_IDLE      = 2'd0;
  localparam logic [1:0] WEN_LOAD_MEM  = 2'd1;
  localparam logic [1:0] WEN_CPU_WRITE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  logic       op_write;
  logic [2:0] victim;
  // Set once a line has been refilled so the re-check is not counted as a new miss.
  logic       refill;

  // State transitions, request/victim latching and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_write <= 1'b0;
      victim   <= 3'd0;
      refill   <= 1'b0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            op_write <= mem_write;
            refill   <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            victim <= lru_way;
            if (!refill && (miss_cnt != CNT_MAX))
              miss_cnt <= miss_cnt + 1'b1;
            state <= victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            if (wb_cnt != CNT_MAX)
              wb_cnt <= wb_cnt + 1'b1;
            state <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            refill <= 1'b1;
            state  <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath control decode; forced to defaults while reset is asserted so an
  // aborted memory transfer cannot emit a strobe in the reset cycle.
  always_comb begin
    mem_resp              = 1'b0;
    pmem_read             = 1'b0;
    pmem_write            = 1'b0;
    pmem_addr_mux_sel     = ADDR_CPU;
    data_in_mux_sel       = DIN_CACHELINE;
    data_write_en_mux_sel = WEN_IDLE;
    way_sel               = 3'd0;
    load_tag              = 1'b0;
    load_valid            = 1'b0;
    set_dirty             = 1'b0;
    clear_dirty           = 1'b0;
    lru_update            = 1'b0;
    if (!rst) begin
      case (state)
        CHECK: begin
          if (hit) begin
            mem_resp   = 1'b1;
            lru_update = 1'b1;
            way_sel    = hit_way;
            if (op_write) begin
              data_write_en_mux_sel = WEN_CPU_WRITE;
              data_in_mux_sel       = DIN_BUS;
              set_dirty             = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          pmem_write        = 1'b1;
          pmem_addr_mux_sel = {1'b0, victim} + 4'd1;
          way_sel           = victim;
          clear_dirty       = pmem_resp;
        end
        ALLOCATE: begin
          pmem_read         = 1'b1;
          pmem_addr_mux_sel = ADDR_CPU;
          way_sel           = victim;
          if (pmem_resp) begin
            data_write_en_mux_sel = WEN_LOAD_MEM;
            data_in_mux_sel       = DIN_CACHELINE;
            load_tag              = 1'b1;
            load_valid            = 1'b1;
            clear_dirty           = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/l2_cache_control.md
L2_CACHE_CONTROL -- requirements
Module: l2_cache_control

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, the width of the saturating performance counters.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mem_read  input  1  upstream read request; held high until mem_resp.
REQ-005 mem_write  input  1  upstream write request; held high until mem_resp.
REQ-006 hit  input  1  datapath tag match in the indexed set, valid one cycle after the request is accepted.
REQ-007 hit_way  input  3  matching way when hit=1.
REQ-008 lru_way  input  3  PLRU victim way of the indexed set.
REQ-009 victim_dirty  input  1  dirty bit of lru_way.
REQ-010 pmem_resp  input  1  physical memory completion pulse.
REQ-011 mem_resp  output  1  one-cycle upstream completion pulse.
REQ-012 pmem_read, pmem_write  output  1 each  physical memory requests.
REQ-013 pmem_addr_mux_sel  output  4  pmem_addr_mux_sel_t: cpu=0, dirty_N_write=N+1.
REQ-014 data_in_mux_sel  output  1  data_in_mux_sel_t: cacheline_adaptor=0, bus_adaptor=1.
REQ-015 data_write_en_mux_sel  output  2  data_write_en_mux_sel_t: idle=0, load_mem=1, cpu_write=2.
REQ-016 way_sel  output  3  target way for data, tag, valid and dirty updates.
REQ-017 load_tag, load_valid, set_dirty, clear_dirty, lru_update  output  1 each  one-cycle datapath strobes.
REQ-018 miss_cnt, wb_cnt  output  CNT_W each  saturating miss and writeback counters.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, CHECK, WRITEBACK, ALLOCATE.
REQ-020 Outputs SHALL be combinational from state and inputs, except the latched way, operation and counters; every output not explicitly driven SHALL be 0, i.e. cpu / cacheline_adaptor / idle.
REQ-021 IDLE: if mem_read or mem_write, latch op_write=mem_write and go to CHECK next cycle; if both are asserted, treat as a write.
REQ-022 CHECK, hit=1: assert mem_resp, lru_update, way_sel=hit_way in the same cycle, then go to IDLE.
REQ-023 CHECK, hit=1 and op_write=1: additionally drive data_write_en_mux_sel=cpu_write, data_in_mux_sel=bus_adaptor, set_dirty.
REQ-024 CHECK, hit=0: latch victim=lru_way and increment miss_cnt; go to WRITEBACK if victim_dirty=1, else ALLOCATE.
REQ-025 WRITEBACK: pmem_write=1, pmem_addr_mux_sel=victim+1, way_sel=victim, held until pmem_resp.
REQ-026 On pmem_resp in WRITEBACK: pulse clear_dirty, increment wb_cnt, go to ALLOCATE.
REQ-027 ALLOCATE: pmem_read=1, pmem_addr_mux_sel=cpu, way_sel=victim, held until pmem_resp.
REQ-028 On pmem_resp in ALLOCATE, in the same cycle: data_write_en_mux_sel=load_mem, data_in_mux_sel=cacheline_adaptor, load_tag, load_valid, clear_dirty; then go to CHECK, which re-evaluates and hits.
REQ-029 Miss latency without a dirty victim SHALL be 1 CHECK + ALLOCATE + 1 CHECK cycle; hit latency SHALL be 2 cycles from request to mem_resp.
REQ-030 pmem_read and pmem_write SHALL never be asserted together; mem_resp SHALL never coincide with pmem_read or pmem_write.
REQ-031 pmem_resp in IDLE or CHECK SHALL be ignored.
REQ-032 Upstream request changes after acceptance SHALL be ignored until the next IDLE.
REQ-033 Counters SHALL saturate at all-ones and never wrap; a miss_cnt increment SHALL occur once per miss, not on the re-check.

Reset
REQ-034 When rst=1 at a clock edge: state=IDLE, op_write=0, victim=0, miss_cnt=0, wb_cnt=0; all outputs at defaults on the following cycle.
REQ-035 Reset mid-WRITEBACK or mid-ALLOCATE SHALL abort without any strobe; a subsequent late pmem_resp SHALL be ignored.

Verification
REQ-036 Read hit, hit_way=5 -> mem_resp and lru_update in cycle 2, way_sel=5, write_en=idle, counters unchanged.
REQ-037 Write hit, hit_way=2 -> write_en=cpu_write, data_in=bus_adaptor, set_dirty, way_sel=2 coincident with mem_resp.
REQ-038 Read miss, lru_way=7, victim_dirty=1, pmem_resp after 10 cycles each -> pmem_addr_mux_sel=8 with pmem_write, then sel=0 with pmem_read, load_mem/load_tag/load_valid strobes, hit, mem_resp; wb_cnt=1, miss_cnt=1.
REQ-039 Clean miss, lru_way=0 -> no pmem_write, ALLOCATE directly, miss_cnt increments exactly once.
REQ-040 With CNT_W=2, 5 misses -> miss_cnt=3.
REQ-041 rst asserted during ALLOCATE, then pmem_resp -> IDLE, no load_tag, counters 0.
